// File: rtl/tinyarch_run_ctrl.sv
// Host-side run sequencer for one tinyarch core: writes the job operand to data memory,
// starts the core, waits for done (with timeout) and returns the 16-bit result word.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ready for a job; host may offer job_valid
// S_WR_LO  | controller owns data memory, writes operand low byte
// S_WR_HI  | controller owns data memory, writes operand high byte
// S_START  | core_start asserted for START_CYC cycles, memory handed to core
// S_RUN    | core running; timeout counter advances, done accepted from 2nd cycle
// S_RD_LO  | controller owns data memory, captures result low byte
// S_RD_HI  | controller owns data memory, captures result high byte
// S_OUT    | result presented until host handshake
module tinyarch_run_ctrl #(
  parameter logic [7:0]  OPA_LO_ADDR = 8'd4,
  parameter logic [7:0]  RES_LO_ADDR = 8'd6,
  parameter int unsigned START_CYC   = 1,
  parameter int unsigned TMO_W       = 12,
  parameter int unsigned TMO_LIMIT   = 4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [15:0] job_operand,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_timeout,
  output logic        busy,
  output logic        core_start,
  input  logic        core_done,
  output logic        dm_sel,
  output logic        dm_wr_en,
  output logic [7:0]  dm_addr,
  output logic [7:0]  dm_wr_data,
  input  logic [7:0]  dm_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LO, S_WR_HI, S_START, S_RUN, S_RD_LO, S_RD_HI, S_OUT
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LIM_C  = TMO_W'(TMO_LIMIT);
  localparam logic [TMO_W-1:0] START_LAST = TMO_W'(START_CYC - 1);

  state_t            state_q, state_d;
  logic [15:0]       op_q, op_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
  logic [15:0]       res_data_q, res_data_d;
  logic              res_timeout_q, res_timeout_d;
  logic              job_ready_q, job_ready_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;
  logic              core_start_q, core_start_d;
  logic              dm_sel_q, dm_sel_d;
  logic              dm_wr_en_q, dm_wr_en_d;
  logic [7:0]        dm_addr_q, dm_addr_d;
  logic [7:0]        dm_wr_data_q, dm_wr_data_d;

  assign tmo_inc = tmo_q + TMO_W'(1);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    tmo_d         = tmo_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    case (state_q)
      S_IDLE: if (job_valid) begin
        op_d          = job_operand;
        res_timeout_d = 1'b0;
        state_d       = S_WR_LO;
      end
      S_WR_LO: state_d = S_WR_HI;
      S_WR_HI: begin
        tmo_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (tmo_q == START_LAST) begin
          tmo_d   = '0;
          state_d = S_RUN;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_RUN: begin
        tmo_d = tmo_inc;
        // tmo_q == 0 marks the first RUN cycle, where a leftover done is ignored
        if (core_done && (tmo_q != '0)) begin
          tmo_d   = '0;
          state_d = S_RD_LO;
        end else if (tmo_inc == TMO_LIM_C) begin
          tmo_d         = '0;
          res_timeout_d = 1'b1;
          res_data_d    = 16'h0000;
          state_d       = S_OUT;
        end
      end
      S_RD_LO: begin
        res_data_d[7:0] = dm_rd_data;
        state_d         = S_RD_HI;
      end
      S_RD_HI: begin
        res_data_d[15:8] = dm_rd_data;
        state_d          = S_OUT;
      end
      S_OUT: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    job_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    res_valid_d  = (state_d == S_OUT);
    core_start_d = (state_d == S_START);
    dm_sel_d     = 1'b0;
    dm_wr_en_d   = 1'b0;
    dm_addr_d    = 8'h00;
    dm_wr_data_d = 8'h00;
    case (state_d)
      S_WR_LO: begin
        dm_sel_d     = 1'b1;
        dm_wr_en_d   = 1'b1;
        dm_addr_d    = OPA_LO_ADDR;
        dm_wr_data_d = op_d[7:0];
      end
      S_WR_HI: begin
        dm_sel_d     = 1'b1;
        dm_wr_en_d   = 1'b1;
        dm_addr_d    = OPA_LO_ADDR + 8'd1;
        dm_wr_data_d = op_d[15:8];
      end
      S_RD_LO: begin
        dm_sel_d  = 1'b1;
        dm_addr_d = RES_LO_ADDR;
      end
      S_RD_HI: begin
        dm_sel_d  = 1'b1;
        dm_addr_d = RES_LO_ADDR + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      op_q          <= 16'h0000;
      tmo_q         <= '0;
      res_data_q    <= 16'h0000;
      res_timeout_q <= 1'b0;
      job_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      core_start_q  <= 1'b0;
      dm_sel_q      <= 1'b0;
      dm_wr_en_q    <= 1'b0;
      dm_addr_q     <= 8'h00;
      dm_wr_data_q  <= 8'h00;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      tmo_q         <= tmo_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      job_ready_q   <= job_ready_d;
      busy_q        <= busy_d;
      res_valid_q   <= res_valid_d;
      core_start_q  <= core_start_d;
      dm_sel_q      <= dm_sel_d;
      dm_wr_en_q    <= dm_wr_en_d;
      dm_addr_q     <= dm_addr_d;
      dm_wr_data_q  <= dm_wr_data_d;
    end
  end

  assign job_ready   = job_ready_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign core_start  = core_start_q;
  assign dm_sel      = dm_sel_q;
  assign dm_wr_en    = dm_wr_en_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wr_data  = dm_wr_data_q;

endmodule

// File: tb/tb_tinyarch_run_ctrl.sv
// Bench for tinyarch_run_ctrl: behavioural data memory and core, table vectors,
// hand-written corner sequences and randomized jobs checked against a cycle-count model.
module tb_tinyarch_run_ctrl;

  localparam int LIM = 50;
  localparam int SC  = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_operand;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_timeout;
  logic        busy;
  logic        core_start;
  logic        core_done;
  logic        dm_sel;
  logic        dm_wr_en;
  logic [7:0]  dm_addr;
  logic [7:0]  dm_wr_data;
  logic [7:0]  dm_rd_data;

  tinyarch_run_ctrl #(
    .OPA_LO_ADDR(8'd4), .RES_LO_ADDR(8'd6), .START_CYC(SC), .TMO_W(12), .TMO_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_operand(job_operand), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_timeout(res_timeout), .busy(busy),
    .core_start(core_start), .core_done(core_done), .dm_sel(dm_sel),
    .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wr_data(dm_wr_data),
    .dm_rd_data(dm_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: controller writes land in mem; the result bytes come from the core model.
  logic [7:0]  mem [0:255];
  logic [15:0] core_res;
  always @(posedge clk) if (dm_sel && dm_wr_en) mem[dm_addr] <= dm_wr_data;
  assign dm_rd_data = (dm_addr == 8'd6) ? core_res[7:0] :
                      (dm_addr == 8'd7) ? core_res[15:8] : mem[dm_addr];

  int n_cmp = 0;
  int n_bad = 0;
  bit pat[$];   // core_done per RUN cycle, index 1 = first RUN cycle

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Completion is the first done in RUN cycles 2..LIM; otherwise the job times out.
  function automatic void model(output bit to, output int n);
    to = 1'b1;
    n  = LIM;
    for (int i = 2; i <= LIM; i++)
      if (i < pat.size() && pat[i]) begin
        to = 1'b0;
        n  = i;
        return;
      end
  endfunction

  function automatic void set_pulse(input int d);
    pat.delete();
    for (int i = 0; i <= d; i++) pat.push_back(d != 0 && i == d);
  endfunction

  // Called at a negedge with the controller idle; returns at the negedge after the handshake.
  task automatic run_job(input string tag, input logic [15:0] op, input logic [15:0] res,
                         input bit pre, input int hold, input logic [15:0] exp_data,
                         input bit exp_to, input int exp_lat);
    int acc, start_cnt, r, bad_wr, bad_run, bad_rdy, bad_sel;
    bit got;
    logic [15:0] d0;
    logic t0;
    start_cnt = 0; r = 0; bad_wr = 0; bad_run = 0; bad_rdy = 0; bad_sel = 0; got = 0;
    core_res    = res;
    core_done   = pre;
    job_valid   = 1'b1;
    job_operand = op;
    chk({tag, " job_ready_idle"}, job_ready, 1'b1);
    acc = cyc + 1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (t == 0) begin
        job_valid   = 1'b0;
        job_operand = 16'($urandom);
      end
      if (dm_wr_en && !dm_sel) bad_wr++;
      if (dm_wr_en && start_cnt > 0) bad_run++;
      if (job_ready && busy) bad_rdy++;
      if (dm_sel && core_start) bad_sel++;
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      if (core_start) start_cnt++;
      else if (start_cnt > 0) begin
        r++;
        core_done = (r < pat.size()) ? pat[r] : 1'b0;
      end
    end
    core_done = 1'b0;
    chk({tag, " res_valid_seen"}, got, 1'b1);
    chk({tag, " latency"}, cyc - acc, exp_lat);
    chk({tag, " res_data"}, res_data, exp_data);
    chk({tag, " res_timeout"}, res_timeout, exp_to);
    chk({tag, " start_cycles"}, start_cnt, SC);
    chk({tag, " operand_mem"}, {mem[5], mem[4]}, op);
    chk({tag, " protocol_errs"}, bad_wr + bad_run + bad_rdy + bad_sel, 0);
    d0 = res_data;
    t0 = res_timeout;
    for (int h = 0; h < hold; h++) begin
      job_valid = 1'b1;
      res_ready = 1'b0;
      @(negedge clk);
      chk({tag, " hold_valid"}, res_valid, 1'b1);
      chk({tag, " hold_data"}, {15'h0, res_timeout, res_data}, {15'h0, t0, d0});
      chk({tag, " hold_no_ready"}, job_ready, 1'b0);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, " after_hs"}, {res_valid, job_ready, busy}, 3'b010);
  endtask

  typedef struct {
    logic [15:0] op;
    logic [15:0] res;
    int          d;
    int          hold;
    logic [15:0] exp_data;
    bit          exp_to;
    int          exp_lat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: actual=expired required=finish");
    $fatal(1);
  end

  initial begin
    bit to;
    int n;
    logic [15:0] op, res;
    tbl[0] = '{16'h3C00, 16'h0001, 20, 0, 16'h0001, 1'b0, 25};
    tbl[1] = '{16'hFB80, 16'h1234,  0, 5, 16'h0000, 1'b1, 53};
    tbl[2] = '{16'h1234, 16'hBEEF,  1, 0, 16'h0000, 1'b1, 53};
    tbl[3] = '{16'hABCD, 16'h5A5A,  2, 5, 16'h5A5A, 1'b0,  7};
    tbl[4] = '{16'h00FF, 16'h8001, 50, 1, 16'h8001, 1'b0, 55};
    tbl[5] = '{16'h7777, 16'h1111, 51, 0, 16'h0000, 1'b1, 53};

    reset = 1'b0; job_valid = 1'b0; job_operand = 16'h0; res_ready = 1'b0;
    core_done = 1'b0; core_res = 16'h0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {job_ready, busy, core_start, dm_sel, dm_wr_en, res_valid, res_timeout},
        7'b1000000);
    chk("reset_bus", {dm_addr, dm_wr_data, res_data}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      set_pulse(tbl[i].d);
      run_job($sformatf("vec%0d", i), tbl[i].op, tbl[i].res, 1'b0, tbl[i].hold,
              tbl[i].exp_data, tbl[i].exp_to, tbl[i].exp_lat);
    end

    // Stale done held through START and the first RUN cycle; completion at RUN cycle 12.
    pat.delete();
    for (int i = 0; i <= 12; i++) pat.push_back(i == 1 || i == 12);
    run_job("stale_done", 16'h4242, 16'hC0DE, 1'b1, 0, 16'hC0DE, 1'b0, 17);

    // Reset in the middle of RUN, then a normal job.
    job_valid = 1'b1; job_operand = 16'h5555; core_done = 1'b0;
    @(negedge clk);
    job_valid = 1'b0;
    for (int t = 0; t < 20 && !core_start; t++) @(negedge clk);
    chk("rst_mid_start_seen", core_start, 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctl", {core_start, dm_sel, res_valid, busy, job_ready, res_timeout}, 6'b000010);
    chk("rst_mid_data", res_data, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_result", res_valid, 1'b0);
    set_pulse(5);
    run_job("after_rst", 16'h6789, 16'h00AA, 1'b0, 0, 16'h00AA, 1'b0, 10);

    // Back-to-back jobs.
    set_pulse(7);
    run_job("b2b0", 16'h3C00, 16'h0001, 1'b0, 0, 16'h0001, 1'b0, 12);
    set_pulse(3);
    run_job("b2b1", 16'h4000, 16'h0002, 1'b0, 0, 16'h0002, 1'b0, 8);
    set_pulse(15);
    run_job("b2b2", 16'hC200, 16'hFFFD, 1'b0, 0, 16'hFFFD, 1'b0, 20);

    // Randomized jobs against the model.
    for (int k = 0; k < 20; k++) begin
      op  = 16'($urandom);
      res = 16'($urandom);
      pat.delete();
      for (int i = 0; i < 60; i++) pat.push_back($urandom_range(0, 19) == 0);
      model(to, n);
      run_job($sformatf("rnd%0d", k), op, res, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), to ? 16'h0000 : res, to,
              to ? 2 + SC + LIM : 4 + SC + n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
